// File: rtl/carry_resolver.sv
// Iterative carry-propagate resolver: turns a half-adder sum/carry pair into a binary total.
// Optional CARRY_RESOLVER_EARLY_EXIT_EN stops iterating as soon as the carry vector clears.
module carry_resolver #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   sum_in,
    input  logic [N-1:0]   carry_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+1:0]   result
);
    localparam int W  = N + 2;
    localparam int CW = $clog2(N + 2) + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid holds its payload steady until that edge, ready never depends on valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   s_q;
    logic [W-1:0]   c_q;
    logic [W-1:0]   s_d;
    logic [W-1:0]   c_d;
    logic [CW-1:0]  iter_cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           run_done;

    // One carry-save step; the carry leaving the MSB is always zero for legal totals.
    assign s_d = s_q ^ c_q;
    assign c_d = (s_q & c_q) << 1;

`ifdef CARRY_RESOLVER_EARLY_EXIT_EN
    assign run_done = (c_q == '0);
`else
    assign run_done = (iter_cnt_q == CW'(N + 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            iter_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q         <= W'(sum_in);
                        c_q         <= W'(carry_in) << 1;
                        iter_cnt_q  <= '0;
                        in_ready_q  <= 1'b0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (run_done) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        s_q        <= s_d;
                        c_q        <= c_d;
                        iter_cnt_q <= iter_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = s_q;

endmodule

// File: tb/tb_carry_resolver.sv
// Self-checking bench for carry_resolver (N=4): directed table, backpressure, reset, random sweep.
module tb_carry_resolver;
    localparam int N   = 4;
    localparam int LAT_FIXED = N + 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] sum_in;
    logic [N-1:0] carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [N+1:0] result;

    int checks = 0;
    int errors = 0;

    carry_resolver #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] s;
        logic [N-1:0] c;
        logic [N+1:0] exp_res;
        int           exp_lat_early;
    } vec_t;

    logic [N+1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference total straight from the operand weights.
    function automatic logic [N+1:0] ref_total(input logic [N-1:0] s, input logic [N-1:0] c);
        int v;
        v = int'(s) + 2 * int'(c);
        return v[N+1:0];
    endfunction

    // Accept one pair, measure edges from accept to out_valid, hold out_ready low for gap cycles.
    task automatic run_txn(input logic [N-1:0] s, input logic [N-1:0] c, input int gap,
                           input bit poke, output int lat, output logic [N+1:0] res);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        sum_in    = s;
        carry_in  = c;
        in_valid  = 1'b1;
        out_ready = (gap == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid) check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check("result_timeout", {31'd0, out_valid}, 32'd1);
        res = result;
        for (int g = 0; g < gap; g++) begin
            if (poke) begin
                in_valid = 1'b1;
                sum_in   = ~s;
                carry_in = ~c;
            end
            @(posedge clk); #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_result", 32'(result), 32'(res));
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_latency(input string name, input int lat, input logic [N-1:0] c,
                                 input int exp_early);
`ifdef CARRY_RESOLVER_EARLY_EXIT_EN
        check(name, 32'(lat), 32'(exp_early));
        check("lat_bound", {31'd0, lat <= LAT_FIXED}, 32'd1);
        if (c == '0) check("lat_zero_carry", 32'(lat), 32'd1);
`else
        check(name, 32'(lat), 32'(LAT_FIXED));
`endif
    endtask

    initial begin
        vec_t         vecs[6];
        int           lat;
        logic [N+1:0] res;
        int           order[$];

        // Early-exit latencies are k+1, with k worked out by hand for each pair.
        vecs[0] = '{4'b1111, 4'b0001, 6'd17, 5};
        vecs[1] = '{4'b1111, 4'b1111, 6'd45, 4};
        vecs[2] = '{4'b1010, 4'b0000, 6'd10, 1};
        vecs[3] = '{4'b0011, 4'b0001, 6'd5,  3};
        vecs[4] = '{4'b0000, 4'b0000, 6'd0,  1};
        vecs[5] = '{4'b0101, 4'b0101, 6'd15, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        carry_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].s, vecs[i].c, 0, 1'b0, lat, res);
            check("vec_result", 32'(res), 32'(vecs[i].exp_res));
            check_latency("vec_latency", lat, vecs[i].c, vecs[i].exp_lat_early);
        end

        // Backpressure with an ignored in_valid during the stall.
        run_txn(4'b1111, 4'b0001, 3, 1'b1, lat, res);
        check("bp_result", 32'(res), 32'd17);
        check_latency("bp_latency", lat, 4'b0001, 5);

        // Reset during the second RUN cycle drops the transaction.
        sum_in   = 4'b1111;
        carry_in = 4'b0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        run_txn(4'b0011, 4'b0001, 0, 1'b0, lat, res);
        check("post_rst_result", 32'(res), 32'd5);
        check_latency("post_rst_latency", lat, 4'b0001, 3);

        // All 256 pairs in random order with random out_ready gaps.
        for (int i = 0; i < 256; i++) order.push_back(i);
        while (order.size() > 0) begin
            int idx;
            int v;
            logic [7:0] pair;
            logic [N+1:0] exp;
            idx  = $urandom_range(0, order.size() - 1);
            v    = order[idx];
            order.delete(idx);
            pair = v[7:0];
            exp_q.push_back(ref_total(pair[3:0], pair[7:4]));
            run_txn(pair[3:0], pair[7:4], $urandom_range(0, 2), 1'($urandom_range(0, 1)), lat, res);
            exp = exp_q.pop_front();
            check("sweep_result", 32'(res), 32'(exp));
`ifdef CARRY_RESOLVER_EARLY_EXIT_EN
            check("sweep_lat_bound", {31'd0, (lat >= 1) && (lat <= LAT_FIXED)}, 32'd1);
            if (pair[7:4] == 4'd0) check("sweep_lat_zero", 32'(lat), 32'd1);
`else
            check("sweep_latency", 32'(lat), 32'(LAT_FIXED));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
